// File: rtl/wbm_spi_cmd_if.sv
// Byte handshake from the SPI receive stage, Wishbone master bus and read-result port.
// master = command stage side, slave = SPI stages plus Wishbone interconnect.
interface wbm_spi_cmd_if;
    logic       handshake_spi;
    logic [7:0] handshake_buffer;
    logic       handshake_wb;
    logic       wb_cyc_o;
    logic       wb_stb_o;
    logic       wb_we_o;
    logic [6:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_ack_i;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;

    modport master (
        input  handshake_spi, handshake_buffer, wb_dat_i, wb_ack_i,
        output handshake_wb, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        output rd_data_o, rd_valid_o
    );

    modport slave (
        output handshake_spi, handshake_buffer, wb_dat_i, wb_ack_i,
        input  handshake_wb, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        input  rd_data_o, rd_valid_o
    );
endinterface

// File: rtl/wbm_spi_cmd.sv
// SPI command bytes -> single Wishbone transfers; toggle-to-consume is SYNC_STAGES+1 edges.
// Bytes are held off (return toggle withheld) while a Wishbone transfer is outstanding.
module wbm_spi_cmd #(
    parameter int SYNC_STAGES = 2
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    wbm_spi_cmd_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_WB
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hs_wb_q, hs_wb_d;
    logic                   we_q, we_d;
    logic [6:0]             adr_q, adr_d;
    logic [7:0]             dat_q, dat_d;
    logic [7:0]             rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   sync;
    logic                   pending;
    logic                   consume;

    assign sync    = sync_q[SYNC_STAGES-1];
    assign pending = sync ^ hs_wb_q;
    assign consume = pending && (state_q != ST_WB);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync_q     <= '0;
            state_q    <= ST_IDLE;
            hs_wb_q    <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.handshake_spi};
            state_q    <= state_d;
            hs_wb_q    <= hs_wb_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hs_wb_d    = hs_wb_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        if (consume) begin
            hs_wb_d = sync;
        end

        unique case (state_q)
            ST_IDLE: begin
                // 0x00 is filler clocked in while the SPI master reads back data
                if (consume && (bus.handshake_buffer != 8'h00)) begin
                    we_d    = bus.handshake_buffer[7];
                    adr_d   = bus.handshake_buffer[6:0];
                    state_d = bus.handshake_buffer[7] ? ST_DATA : ST_WB;
                end
            end
            ST_DATA: begin
                if (consume) begin
                    dat_d   = bus.handshake_buffer;
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (bus.wb_ack_i) begin
                    state_d = ST_IDLE;
                    if (!we_q) begin
                        rd_data_d  = bus.wb_dat_i;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.handshake_wb = hs_wb_q;
    assign bus.wb_cyc_o     = (state_q == ST_WB);
    assign bus.wb_stb_o     = (state_q == ST_WB);
    assign bus.wb_we_o      = we_q;
    assign bus.wb_adr_o     = adr_q;
    assign bus.wb_dat_o     = dat_q;
    assign bus.rd_data_o    = rd_data_q;
    assign bus.rd_valid_o   = rd_valid_q;

endmodule

// File: tb/tb_wbm_spi_cmd.sv
// Directed bench for wbm_spi_cmd with a programmable-delay Wishbone slave and a bus monitor.
module tb_wbm_spi_cmd;

    localparam int SYNC = 3;

    logic clk;
    logic rst_n;
    wbm_spi_cmd_if bus ();

    wbm_spi_cmd #(.SYNC_STAGES(SYNC)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slave: acks after ack_delay cycles of cyc
    int ack_delay = 0;
    int wait_cnt  = 0;
    initial begin
        bus.wb_ack_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.wb_cyc_o) begin
                bus.wb_ack_i = (wait_cnt == ack_delay);
                wait_cnt++;
            end else begin
                bus.wb_ack_i = 1'b0;
                wait_cnt     = 0;
            end
        end
    end

    int         xfers, cyc_cycles, rdv_cnt, toggles;
    logic       last_we, prev_cyc, prev_hs;
    logic [6:0] last_adr;
    logic [7:0] last_dat;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.wb_cyc_o) cyc_cycles++;
            if (bus.wb_cyc_o && !prev_cyc) begin
                xfers++;
                last_we  = bus.wb_we_o;
                last_adr = bus.wb_adr_o;
                last_dat = bus.wb_dat_o;
            end
            if (bus.rd_valid_o) rdv_cnt++;
            if (bus.handshake_wb != prev_hs) toggles++;
            prev_cyc = bus.wb_cyc_o;
            prev_hs  = bus.handshake_wb;
        end
    end

    task automatic clr_mon();
        xfers      = 0;
        cyc_cycles = 0;
        rdv_cnt    = 0;
        toggles    = 0;
        prev_cyc   = bus.wb_cyc_o;
        prev_hs    = bus.handshake_wb;
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic send(input logic [7:0] b);
        bus.handshake_buffer = b;
        bus.handshake_spi    = ~bus.handshake_spi;
    endtask

    task automatic wait_back(output int n);
        n = 0;
        while ((bus.handshake_wb != bus.handshake_spi) && (n < 100)) begin
            tick();
            n++;
        end
        if (bus.handshake_wb != bus.handshake_spi)
            chk("hs_timeout", 32'(bus.handshake_wb), 32'(bus.handshake_spi));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.wb_cyc_o && (n < 100)) begin
            tick();
            n++;
        end
        if (bus.wb_cyc_o) chk("cyc_timeout", 32'(bus.wb_cyc_o), 0);
    endtask

    initial begin
        int n, low, viol;
        rst_n                = 1'b0;
        bus.handshake_spi    = 1'b1;
        bus.handshake_buffer = 8'h00;
        bus.wb_dat_i         = 8'h00;
        clr_mon();
        repeat (3) tick();

        chk("rst_hs_wb",    32'(bus.handshake_wb), 0);
        chk("rst_cyc",      32'(bus.wb_cyc_o), 0);
        chk("rst_stb",      32'(bus.wb_stb_o), 0);
        chk("rst_we",       32'(bus.wb_we_o), 0);
        chk("rst_adr",      32'(bus.wb_adr_o), 0);
        chk("rst_dat",      32'(bus.wb_dat_o), 0);
        chk("rst_rd_data",  32'(bus.rd_data_o), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid_o), 0);

        // spi toggle already high at reset release counts as one pending byte
        rst_n = 1'b1;
        wait_back(n);
        chk("rst_pending_lat", n, SYNC + 1);
        chk("rst_pending_hs",  32'(bus.handshake_wb), 1);

        tick();
        send(8'h00);
        wait_back(n);
        chk("toggle_lat", n, SYNC + 1);

        // write 0x85, 0x3C
        ack_delay = 2;
        clr_mon();
        send(8'h85);
        wait_back(n);
        send(8'h3C);
        wait_back(n);
        wait_idle();
        tick();
        chk("wr_xfers",  xfers, 1);
        chk("wr_we",     32'(last_we), 1);
        chk("wr_adr",    32'(last_adr), 32'h05);
        chk("wr_dat",    32'(last_dat), 32'h3C);
        chk("wr_cycles", cyc_cycles, 3);
        chk("wr_toggles", toggles, 2);
        chk("wr_rdv",    rdv_cnt, 0);

        // read 0x12, zero-wait slave returning 0xA7
        ack_delay    = 0;
        bus.wb_dat_i = 8'hA7;
        clr_mon();
        send(8'h12);
        wait_back(n);
        wait_idle();
        repeat (2) tick();
        chk("rd_xfers",   xfers, 1);
        chk("rd_we",      32'(last_we), 0);
        chk("rd_adr",     32'(last_adr), 32'h12);
        chk("rd_cycles",  cyc_cycles, 1);
        chk("rd_data",    32'(bus.rd_data_o), 32'hA7);
        chk("rd_valid_n", rdv_cnt, 1);
        chk("rd_toggles", toggles, 1);

        // NOPs
        clr_mon();
        send(8'h00);
        wait_back(n);
        send(8'h00);
        wait_back(n);
        repeat (3) tick();
        chk("nop_toggles", toggles, 2);
        chk("nop_xfers",   xfers, 0);

        // backpressure: second byte waits until the cycle after the ack
        ack_delay    = 20;
        bus.wb_dat_i = 8'h5A;
        clr_mon();
        send(8'h01);
        wait_back(n);
        send(8'h00);
        n    = 0;
        low  = 0;
        viol = 0;
        while ((bus.handshake_wb != bus.handshake_spi) && (n < 100)) begin
            tick();
            n++;
            if (bus.wb_cyc_o && (bus.handshake_wb == bus.handshake_spi)) viol++;
            if (!bus.wb_cyc_o) low++;
        end
        chk("bp_returned", 32'(bus.handshake_wb), 32'(bus.handshake_spi));
        chk("bp_viol",     viol, 0);
        chk("bp_low",      low, 2);
        tick();
        chk("bp_xfers",    xfers, 1);
        chk("bp_cycles",   cyc_cycles, 21);
        chk("bp_rdv",      rdv_cnt, 1);
        chk("bp_rd_data",  32'(bus.rd_data_o), 32'h5A);

        // reset in the middle of a stalled read
        ack_delay = 1000;
        send(8'h00);
        wait_back(n);
        send(8'h40);
        wait_back(n);
        tick();
        chk("mid_pre_cyc", 32'(bus.wb_cyc_o), 1);
        chk("mid_pre_hs",  32'(bus.handshake_wb), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_cyc",      32'(bus.wb_cyc_o), 0);
        chk("mid_stb",      32'(bus.wb_stb_o), 0);
        chk("mid_hs_wb",    32'(bus.handshake_wb), 0);
        chk("mid_rd_valid", 32'(bus.rd_valid_o), 0);
        bus.handshake_spi = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        ack_delay = 0;
        clr_mon();
        send(8'hFF);
        wait_back(n);
        send(8'h55);
        wait_back(n);
        wait_idle();
        tick();
        chk("post_xfers", xfers, 1);
        chk("post_we",    32'(last_we), 1);
        chk("post_adr",   32'(last_adr), 32'h7F);
        chk("post_dat",   32'(last_dat), 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wbm_spi_cmd.md
# wbm_spi_cmd

Wishbone-domain command stage that consumes bytes produced by the SPI receive stage across the toggle handshake and turns them into single Wishbone master transfers. Each received command byte selects read or write and a 7-bit address. Write commands take one following data byte. Read results are handed to the SPI transmit stage. The block sits between the SPI receiver's clock-domain export and the Wishbone interconnect, entirely in the Wishbone clock domain.

## Interface
- SYNC_STAGES, 2, number of flip-flops synchronising `handshake_spi`; minimum 2.

- wb_clk_i  in  1  Wishbone clock; sole clock of the block.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- handshake_spi  in  1  toggle from the SPI receive stage; a change means a new byte is in `handshake_buffer`.
- handshake_buffer  in  8  received byte; stable while `handshake_spi` differs from `handshake_wb`.
- handshake_wb  out  1  return toggle; set equal to the synchronised `handshake_spi` when the byte is consumed.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe; always equal to `wb_cyc_o`.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  7  address.
- wb_dat_o  out  8  write data.
- wb_dat_i  in  8  read data.
- wb_ack_i  in  1  slave acknowledge.
- rd_data_o  out  8  last read result, for the SPI transmit stage.
- rd_valid_o  out  1  one-cycle pulse when `rd_data_o` updates.

## Operation
- Synchroniser: `handshake_spi` passes through SYNC_STAGES flops; `sync` is the last stage.
- A byte is pending when `sync != handshake_wb`.
- A byte is consumed only in IDLE or DATA state. Consuming it means:
  - capture `handshake_buffer`;
  - `handshake_wb <= sync` at the same edge.
- Pending bytes are not consumed in WB state. The SPI side sees backpressure; no byte is ever dropped.
- States:
  - IDLE:
    - consumed byte 0x00 is a NOP (filler clocked during reads); stay in IDLE.
    - otherwise latch `we = byte[7]` and `wb_adr_o = byte[6:0]`.
    - if `we`=1, go to DATA.
    - if `we`=0, go to WB.
  - DATA: consumed byte goes to `wb_dat_o`; go to WB.
  - WB: `wb_cyc_o`=`wb_stb_o`=1 and `wb_we_o`=`we`, held until `wb_ack_i` is sampled high. On that edge:
    - drop cyc/stb and return to IDLE;
    - if read, `rd_data_o <= wb_dat_i` and `rd_valid_o` <= 1 for one cycle.
- Consequence: read of address 0 is not expressible; address 0 is reserved.
- `wb_adr_o`, `wb_dat_o` and `wb_we_o` hold their last values outside WB.
- `wb_ack_i` outside WB is ignored.
- No timeout: a slave that never acks stalls the block until reset.

## Timing
- Reset values: `handshake_wb`, `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `rd_valid_o` = 0. `wb_adr_o`, `wb_dat_o`, `rd_data_o` = 0. State = IDLE. Synchroniser flops = 0.
- Reset asserted mid-transfer drops `wb_cyc_o`/`wb_stb_o` immediately (asynchronous).
- After reset, if `handshake_spi`=1, it is seen as one pending byte once synchronised.
- Input toggle to `handshake_wb` toggle: SYNC_STAGES+1 `wb_clk_i` edges when in IDLE/DATA.
- Read command byte consumed at edge N: `wb_cyc_o` high from edge N+1.
- Write data byte consumed at edge N: `wb_cyc_o` high from edge N+1.
- `wb_ack_i` high at edge M: `wb_cyc_o` low after M. For a read, `rd_valid_o` is high for cycle M..M+1 only.
- Zero-wait slave (ack in the first cycle of cyc): transfer is exactly 1 cycle.
- New byte pending at the same edge as ack: held at that edge, consumed at the next edge (state now IDLE).
- Throughput: at most one byte consumed per cycle; back-to-back pending bytes in IDLE/DATA are consumed on consecutive qualifying edges.

## Test plan
- Write: bytes 0x85 then 0x3C, ack after 2 cycles -> one cycle with we=1, adr=0x05, dat_o=0x3C. `handshake_wb` toggles twice. `rd_valid_o` stays 0.
- Read: byte 0x12, slave returns 0xA7 with immediate ack -> cyc high exactly 1 cycle with we=0, adr=0x12. `rd_data_o`=0xA7. `rd_valid_o` pulses once.
- NOP: bytes 0x00, 0x00 -> `handshake_wb` toggles twice. `wb_cyc_o` never asserts.
- Backpressure: byte 0x01 while slave withholds ack 20 cycles, second byte 0x00 sent meanwhile -> second toggle not returned until the cycle after ack. Exactly one read issued.
- Reset mid-cycle: assert `wb_rst_ni`=0 during WB -> cyc/stb/`handshake_wb`/`rd_valid_o` = 0 immediately. After release, a fresh write 0xFF,0x55 gives adr=0x7F, dat_o=0x55.
- Latency check with SYNC_STAGES=3: toggle `handshake_spi` -> `handshake_wb` follows after exactly 4 clock edges.
